// File: rtl/display_scan_controller.sv
// Scan scheduler for an 8-digit common-anode 7-segment display.
// Handles digit sequencing, dead time between digits, PWM brightness,
// leading-zero blanking and hex decode. New frames arrive through a
// valid/ready handshake into a shadow buffer. The shadow buffer is copied
// into the active buffer only at a frame boundary, so a frame never tears.
module display_scan_controller #(
  parameter int SLOT_CYC = 100000,
  parameter int DEAD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [39:0] wr_data,
  input  logic [7:0]  wr_mask,
  input  logic        lzb_en,
  input  logic [3:0]  brightness,
  output logic [2:0]  anode_sel,
  output logic [7:0]  anodos,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_sync
);

  localparam int STEP_CYC = (SLOT_CYC - DEAD_CYC) / 16;
  localparam int TW       = $clog2(SLOT_CYC);

  localparam logic [TW-1:0] LAST_T = TW'(SLOT_CYC - 1);
  localparam logic [TW-1:0] DEAD_T = TW'(DEAD_CYC);
  localparam logic [TW-1:0] STEP_T = TW'(STEP_CYC);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    digit_q, digit_d;
  logic          pending_q, pending_d;
  logic [39:0]   shad_data_q, shad_data_d;
  logic [7:0]    shad_mask_q, shad_mask_d;
  logic [39:0]   act_data_q, act_data_d;
  logic [7:0]    act_mask_q, act_mask_d;
  logic [3:0]    br_q, br_d;
  logic          lzb_q, lzb_d;
  logic [7:0]    anodos_q, anodos_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [2:0]    sel_q, sel_d;
  logic          fsync_q, fsync_d;

  logic          boundary;
  logic [7:0]    blank;
  logic          zero_run;
  logic [4:0]    cur;
  logic [TW-1:0] on_lim;
  logic          lit;

  // Slot/digit counters, handshake and the frame-boundary buffer swap
  always_comb begin
    tick_d      = tick_q + TW'(1);
    digit_d     = digit_q;
    boundary    = (digit_q == 3'd7) && (tick_q == LAST_T);
    pending_d   = pending_q;
    shad_data_d = shad_data_q;
    shad_mask_d = shad_mask_q;
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    br_d        = br_q;
    lzb_d       = lzb_q;
    fsync_d     = 1'b0;
    if (tick_q == LAST_T) begin
      tick_d  = '0;
      digit_d = digit_q + 3'd1;
    end
    if (boundary) begin
      fsync_d = 1'b1;
      br_d    = brightness;
      lzb_d   = lzb_en;
      if (pending_q) begin
        act_data_d = shad_data_q;
        act_mask_d = shad_mask_q;
        pending_d  = 1'b0;
      end
    end
    // pending_q is 0 whenever a write is taken, so this never races the swap
    if (wr_valid && !pending_q) begin
      shad_data_d = wr_data;
      shad_mask_d = wr_mask;
      pending_d   = 1'b1;
    end
  end

  // Leading-zero blanking: blank zero digits from the left until the first nonzero
  always_comb begin
    blank    = '0;
    zero_run = lzb_q;
    for (int i = 7; i >= 1; i--) begin
      if (zero_run && (act_data_q[5*i +: 4] == 4'h0)) begin
        blank[i] = 1'b1;
      end else begin
        zero_run = 1'b0;
      end
    end
  end

  // Phase decode and segment drive for the next registered output
  always_comb begin
    cur      = act_data_q[int'(digit_q)*5 +: 5];
    on_lim   = DEAD_T + TW'(br_q) * STEP_T;
    lit      = (tick_q >= DEAD_T) && (tick_q < on_lim) &&
               act_mask_q[digit_q] && !blank[digit_q];
    anodos_d = 8'hFF;
    seg_d    = 7'h7F;
    dp_d     = 1'b1;
    sel_d    = digit_q;
    if (lit) begin
      anodos_d = ~(8'h01 << digit_q);
      seg_d    = hex_to_seg(cur[3:0]);
      dp_d     = ~cur[4];
    end
  end

  // State and output registers; the shadow buffer needs no reset
  always_ff @(posedge clk) begin
    shad_data_q <= shad_data_d;
    shad_mask_q <= shad_mask_d;
    if (rst) begin
      tick_q     <= '0;
      digit_q    <= '0;
      pending_q  <= 1'b0;
      act_data_q <= '0;
      act_mask_q <= '0;
      br_q       <= '0;
      lzb_q      <= 1'b0;
      anodos_q   <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      sel_q      <= '0;
      fsync_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      digit_q    <= digit_d;
      pending_q  <= pending_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      br_q       <= br_d;
      lzb_q      <= lzb_d;
      anodos_q   <= anodos_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      fsync_q    <= fsync_d;
    end
  end

  assign wr_ready   = ~pending_q;
  assign anodos     = anodos_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign anode_sel  = sel_q;
  assign frame_sync = fsync_q;

endmodule
